m_dmem_ctrl: RTL

Memory-stage data-access controller for the pipelined MIPS core. It sits between the M-stage pipeline register and the data-memory bus. It turns a load/store request (address, size, store data) into a word-aligned bus transaction with byte enables and waits for a variable-latency acknowledge, stalling the pipeline meanwhile. It then presents the returned raw word and byte offset to the downstream load-extension stage. It also flags misaligned or out-of-range accesses as AdEL/AdES instead of issuing them.

---
 rtl/m_dmem_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/m_dmem_ctrl.sv
// M-stage data-memory access controller: legality check, bus issue with byte lanes,
// variable-latency acknowledge wait and hand-off of the raw load word to the extender.
module m_dmem_ctrl #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_kill,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        rd_valid,
  output logic [31:0] rd_word,
  output logic [1:0]  rd_a,
  output logic        exc,
  output logic [4:0]  exc_code
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_byteen_q, bus_byteen_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_word_q, rd_word_d;
  logic [1:0]  rd_a_q, rd_a_d;

  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic        misaligned, out_of_range, legal, live_req, issue;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data;

  // Request decode: access width, alignment/range legality and lane placement.
  always_comb begin
    unique case (req_size)
      2'd0:    nbytes = 3'd1;
      2'd1:    nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    misaligned   = ((req_size == 2'd1) && req_addr[0]) ||
                   ((req_size[1]) && (req_addr[1:0] != 2'b00));
    // Sum is one bit wider so an access near 4 GiB cannot wrap back into range.
    end_addr     = {1'b0, req_addr} + {30'd0, nbytes};
    out_of_range = (req_addr >= ADDR_LIMIT) || (end_addr > {1'b0, ADDR_LIMIT});
    legal        = !misaligned && !out_of_range;
    live_req     = (state_q == S_IDLE) && req_valid && !req_kill;
    issue        = live_req && legal;

    unique case (req_size)
      2'd0: begin
        lane_mask = 4'b0001 << req_addr[1:0];
        lane_data = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        lane_mask = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{req_wdata[15:0]}};
      end
      default: begin
        lane_mask = 4'b1111;
        lane_data = req_wdata;
      end
    endcase
  end

  assign stall    = issue || (state_q == S_WAIT);
  assign exc      = live_req && !legal;
  assign exc_code = exc ? (req_we ? 5'd5 : 5'd4) : 5'd0;

  // NOTE: every _d starts from a default so no path through the case leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_byteen_d = bus_byteen_q;
    bus_wdata_d  = bus_wdata_q;
    rd_valid_d   = 1'b0;
    rd_word_d    = rd_word_q;
    rd_a_d       = rd_a_q;

    unique case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d      = S_WAIT;
          bus_req_d    = 1'b1;
          bus_we_d     = req_we;
          bus_addr_d   = {req_addr[31:2], 2'b00};
          bus_byteen_d = lane_mask;
          bus_wdata_d  = lane_data;
          rd_a_d       = req_addr[1:0];
        end
      end
      S_WAIT: begin
        // The transaction cannot be aborted, so req_kill is not looked at here.
        if (bus_ack) begin
          state_d      = S_DONE;
          bus_req_d    = 1'b0;
          bus_byteen_d = 4'b0000;
          if (!bus_we_q) begin
            rd_word_d  = bus_rdata;
            rd_valid_d = 1'b1;
          end
        end
      end
      default: begin
        // req_valid here still belongs to the instruction that just completed.
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_byteen_q <= '0;
      bus_wdata_q  <= '0;
      rd_valid_q   <= 1'b0;
      rd_word_q    <= '0;
      rd_a_q       <= '0;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_byteen_q <= bus_byteen_d;
      bus_wdata_q  <= bus_wdata_d;
      rd_valid_q   <= rd_valid_d;
      rd_word_q    <= rd_word_d;
      rd_a_q       <= rd_a_d;
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_byteen = bus_byteen_q;
  assign bus_wdata  = bus_wdata_q;
  assign rd_valid   = rd_valid_q;
  assign rd_word    = rd_word_q;
  assign rd_a       = rd_a_q;

endmodule
